// File: rtl/prog_pulse_counter.sv
// Programmable pulse generator: one-cycle tick every N enabled clocks, periodic or one-shot.
// Optional PULSE_COUNT_EN adds a saturating 16-bit count of emitted pulses on port pulse_cnt.
module prog_pulse_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          ONESHOT_RV = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] load,
    output logic             pulse,
    output logic             busy,
    output logic [WIDTH-1:0] count
`ifdef PULSE_COUNT_EN
    ,
    output logic [15:0]      pulse_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             mode_q, mode_d;
    logic             pulse_q, pulse_d;
    logic             terminal;

    assign terminal = (counter_q == period_q - WIDTH'(1));

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        period_d  = period_q;
        mode_d    = mode_q;
        pulse_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // stop outranks start; a zero period is never accepted
                if (!stop && start && (load != '0)) begin
                    period_d  = load;
                    mode_d    = oneshot;
                    counter_d = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d   = StIdle;
                    counter_d = '0;
                end else if (start) begin
                    counter_d = '0;
                    if (load != '0) begin
                        period_d = load;
                        mode_d   = oneshot;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (en) begin
                    if (terminal) begin
                        pulse_d   = 1'b1;
                        counter_d = '0;
                        if (mode_q) begin
                            state_d = StIdle;
                        end
                    end else begin
                        counter_d = counter_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            counter_q <= '0;
            period_q  <= '0;
            mode_q    <= ONESHOT_RV;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = (state_q == StRun);
    assign count = counter_q;

`ifdef PULSE_COUNT_EN
    logic [15:0] pulse_cnt_q;
    logic        cnt_clr;

    // Only an accepted start from idle moves Idle -> Run, so that transition clears the tally
    assign cnt_clr = (state_q == StIdle) && (state_d == StRun);

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt_q <= '0;
        end else if (cnt_clr) begin
            pulse_cnt_q <= '0;
        end else if (pulse_d && (pulse_cnt_q != 16'hFFFF)) begin
            pulse_cnt_q <= pulse_cnt_q + 16'd1;
        end
    end

    assign pulse_cnt = pulse_cnt_q;
`endif

endmodule

// File: tb/tb_prog_pulse_counter.sv
// Bench for prog_pulse_counter: directed scenarios with literal expectations plus random
// stimulus checked every cycle against an enabled-edge-counting reference model.
module tb_prog_pulse_counter;

    localparam int unsigned W      = 8;
    localparam bit          ONE_RV = 1'b0;

    logic         clk = 1'b0;
    logic         rst, start, stop, en, oneshot;
    logic [W-1:0] load;
    logic         pulse, busy;
    logic [W-1:0] count;
`ifdef PULSE_COUNT_EN
    logic [15:0]  pulse_cnt;
`endif

    prog_pulse_counter #(
        .WIDTH      (W),
        .ONESHOT_RV (ONE_RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .en        (en),
        .oneshot   (oneshot),
        .load      (load),
        .pulse     (pulse),
        .busy      (busy),
        .count     (count)
`ifdef PULSE_COUNT_EN
        ,
        .pulse_cnt (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a run counts enabled edges since start; every Nth one is a pulse.
    bit m_run   = 1'b0;
    int m_n     = 0;
    bit m_one   = ONE_RV;
    int m_seen  = 0;
    bit m_pulse = 1'b0;
    int m_pcnt  = 0;

    task automatic model_step();
        if (rst) begin
            m_run = 0; m_n = 0; m_one = ONE_RV; m_seen = 0; m_pulse = 0; m_pcnt = 0;
        end else begin
            m_pulse = 0;
            if (stop) begin
                m_run = 0; m_seen = 0;
            end else if (start && load != 0) begin
                if (!m_run) m_pcnt = 0;
                m_run = 1; m_n = int'(load); m_one = oneshot; m_seen = 0;
            end else if (start && m_run) begin
                m_run = 0; m_seen = 0;
            end else if (m_run && en) begin
                m_seen++;
                if (m_seen % m_n == 0) begin
                    m_pulse = 1;
                    if (m_pcnt < 65535) m_pcnt++;
                    if (m_one) begin
                        m_run = 0; m_seen = 0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit cmp_on = 1'b0;

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            chk("model_pulse", 32'(pulse), 32'(m_pulse));
            chk("model_busy", 32'(busy), 32'(m_run));
            chk("model_count", 32'(count), m_run ? 32'(m_seen % m_n) : 32'd0);
`ifdef PULSE_COUNT_EN
            chk("model_pulse_cnt", 32'(pulse_cnt), 32'(m_pcnt));
`endif
        end
    end

    task automatic wait_pulse(input int max, output int k);
        k = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (pulse === 1'b1) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [W-1:0] ld, input logic os);
        start = 1'b1; load = ld; oneshot = os;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    int n;
    int first;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; oneshot = 1'b0; load = '0;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst = 1'b0;

        // 1: periodic N=10
        en = 1'b1;
        do_start(8'd10, 1'b0);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int p = 1; p <= 3; p++) begin
            wait_pulse(40, n);
            chk("t1_period", 32'(n), 32'd10);
            chk("t1_wrap", 32'(count), 32'd0);
`ifdef PULSE_COUNT_EN
            chk("t1_pulse_cnt", 32'(pulse_cnt), 32'(p));
`endif
        end
        do_stop();

        // 2: N=1 periodic, then one-shot retrigger
        do_start(8'd1, 1'b0);
        chk("t2_first", 32'(pulse), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t2_every", 32'(pulse), 32'd1);
        end
        do_start(8'd1, 1'b1);
        chk("t2_retrig_pulse", 32'(pulse), 32'd0);
        chk("t2_retrig_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t2_os_pulse", 32'(pulse), 32'd1);
        chk("t2_os_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t2_os_after", 32'(pulse), 32'd0);

        // 3: N=5 with en toggling
        en = 1'b0;
        do_start(8'd5, 1'b0);
        first = -1;
        for (int k = 1; k <= 12; k++) begin
            en = k[0];
            @(negedge clk);
            if (k == 2) chk("t3_hold", 32'(count), 32'd1);
            if (pulse === 1'b1 && first < 0) first = k;
        end
        chk("t3_edge", 32'(first), 32'd9);
        do_stop();

        // 4: stop on terminal cycle, retrigger mid-run
        en = 1'b1;
        do_start(8'd8, 1'b0);
        repeat (7) @(negedge clk);
        chk("t4_cnt7", 32'(count), 32'd7);
        do_stop();
        chk("t4_stop_pulse", 32'(pulse), 32'd0);
        chk("t4_stop_busy", 32'(busy), 32'd0);
        chk("t4_stop_count", 32'(count), 32'd0);
        do_start(8'd8, 1'b0);
        repeat (4) @(negedge clk);
        chk("t4_cnt4", 32'(count), 32'd4);
        do_start(8'd3, 1'b0);
        chk("t4_retrig_count", 32'(count), 32'd0);
        wait_pulse(10, n);
        chk("t4_retrig_edge", 32'(n), 32'd3);
        do_stop();

        // 5: zero load ignored, maximum period
        do_start(8'd0, 1'b0);
        repeat (3) begin
            chk("t5_zero_busy", 32'(busy), 32'd0);
            chk("t5_zero_pulse", 32'(pulse), 32'd0);
            @(negedge clk);
        end
        do_start(8'd255, 1'b0);
        wait_pulse(300, n);
        chk("t5_max_edge", 32'(n), 32'd255);
        do_stop();

        // 6: reset mid-run
        do_start(8'd10, 1'b0);
        repeat (6) @(negedge clk);
        chk("t6_cnt6", 32'(count), 32'd6);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pulse", 32'(pulse), 32'd0);
`ifdef PULSE_COUNT_EN
        chk("t6_pulse_cnt", 32'(pulse_cnt), 32'd0);
`endif
        rst = 1'b0;

        // Random phase: load/oneshot change freely mid-run
        repeat (3000) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 199) == 0);
            stop    = ($urandom_range(0, 39) == 0);
            start   = ($urandom_range(0, 14) == 0);
            en      = ($urandom_range(0, 3) != 0);
            oneshot = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       load = '0;
                1:       load = 8'd255;
                default: load = W'($urandom_range(1, 12));
            endcase
        end
        @(negedge clk);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
